// File: rtl/pipe_skid_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake with a 2-entry skid, flush and stall profiling.
// Every output is a flop, so no combinational path runs from i_ready to o_ready.
//
// state | meaning
// EMPTY | nothing held, o_data shows the bubble value
// ONE   | main register holds the head payload
// FULL  | main holds the head payload, skid holds the next one, upstream is stalled
module pipe_skid_buf #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  output logic [1:0]        o_count,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // o_data is the main register itself; o_ready/o_valid/o_count are kept in step with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      o_data  <= NOP_VAL;
      skid    <= NOP_VAL;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
      o_count <= 2'd0;
    end else if (i_flush) begin
      // An out_fire this cycle has already been taken by downstream; incoming data is dropped.
      state   <= EMPTY;
      o_data  <= NOP_VAL;
      skid    <= NOP_VAL;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      o_count <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          o_ready <= 1'b1;
          if (in_fire) begin
            state   <= ONE;
            o_data  <= i_data;
            o_valid <= 1'b1;
            o_count <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state   <= FULL;
            skid    <= i_data;
            o_ready <= 1'b0;
            o_count <= 2'd2;
          end else if (out_fire && !in_fire) begin
            state   <= EMPTY;
            o_data  <= NOP_VAL;
            o_valid <= 1'b0;
            o_count <= 2'd0;
          end else if (in_fire && out_fire) begin
            o_data <= i_data;
          end
        end
        FULL: begin
          // o_ready is low here, so only the downstream side can move.
          if (out_fire) begin
            state   <= ONE;
            o_data  <= skid;
            skid    <= NOP_VAL;
            o_ready <= 1'b1;
            o_count <= 2'd1;
          end
        end
        default: begin
          state   <= EMPTY;
          o_data  <= NOP_VAL;
          skid    <= NOP_VAL;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          o_count <= 2'd0;
        end
      endcase
    end
  end

  // Stall profiling counts flush cycles too and sticks at all-ones until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stall_cnt <= '0;
    end else if (o_valid && !i_ready && (o_stall_cnt != {CNT_W{1'b1}})) begin
      o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: directed vectors plus random traffic, checked by a queue scoreboard.
// A second small instance exercises stall-counter saturation.
module tb_pipe_skid_buf;

  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_flush = 1'b0;
  logic [63:0] i_data  = '0;
  logic        o_ready;
  logic        o_valid;
  logic [63:0] o_data;
  logic [1:0]  o_count;
  logic [15:0] o_stall_cnt;

  logic        s_valid = 1'b0;
  logic        s_ready = 1'b0;
  logic        s_flush = 1'b0;
  logic [7:0]  s_data  = '0;
  logic        s_o_ready;
  logic        s_o_valid;
  logic [7:0]  s_o_data;
  logic [1:0]  s_o_count;
  logic [3:0]  s_stall;

  pipe_skid_buf #(.DATA_W(64), .NOP_VAL(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .i_flush(i_flush),
    .o_count(o_count), .o_stall_cnt(o_stall_cnt)
  );

  pipe_skid_buf #(.DATA_W(8), .NOP_VAL(8'h00), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .i_valid(s_valid), .o_ready(s_o_ready), .i_data(s_data),
    .o_valid(s_o_valid), .i_ready(s_ready), .o_data(s_o_data), .i_flush(s_flush),
    .o_count(s_o_count), .o_stall_cnt(s_stall)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [63:0] q[$];
  logic [63:0] rx[$];
  logic [63:0] exp_rx[$];
  logic        m_rdy   = 1'b0;
  logic [15:0] m_stall = '0;
  logic        m_ev, m_in, m_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: q is what the buffer should hold, head first; rx logs what downstream took.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_data", o_data, NOP);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_stall", 64'(o_stall_cnt), 64'd0);
        q.delete();
        m_rdy   = 1'b0;
        m_stall = '0;
      end else begin
        m_ev = (q.size() != 0);
        chk("valid", 64'(o_valid), 64'(m_ev));
        chk("ready", 64'(o_ready), 64'(m_rdy));
        chk("count", 64'(o_count), 64'(q.size()));
        chk("stall", 64'(o_stall_cnt), 64'(m_stall));
        if (m_ev) chk("data", o_data, q[0]);
        else      chk("bubble", o_data, NOP);
        m_in  = i_valid && m_rdy;
        m_out = m_ev && i_ready;
        if (m_ev && !i_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (m_out) begin
          rx.push_back(o_data);
          void'(q.pop_front());
        end
        if (i_flush) q.delete();
        else if (m_in) q.push_back(i_data);
        m_rdy = (q.size() != 2);
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic r, input logic f);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string name);
    chk({name, "_len"}, 64'(rx.size()), 64'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rx.size(); i++) chk(name, rx[i], exp_rx[i]);
    rx.delete();
    exp_rx.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      step(1, 64'(i), 1, 0);
      chk("stream_data", o_data, 64'(i));
      chk("stream_count", 64'(o_count), 64'd1);
      chk("stream_ready", 64'(o_ready), 64'd1);
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) exp_rx.push_back(64'(i));
    check_rx("stream_order");

    // backpressure: A,B held, C waits upstream
    step(1, 64'hA, 0, 0);
    step(1, 64'hB, 0, 0);
    chk("bp_count", 64'(o_count), 64'd2);
    chk("bp_ready", 64'(o_ready), 64'd0);
    chk("bp_data", o_data, 64'hA);
    step(1, 64'hC, 0, 0);
    step(1, 64'hC, 0, 0);
    chk("bp_hold", o_data, 64'hA);
    step(1, 64'hC, 1, 0);
    step(1, 64'hC, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    exp_rx.push_back(64'hA);
    exp_rx.push_back(64'hB);
    exp_rx.push_back(64'hC);
    check_rx("bp_order");

    // flush while full: A2 consumed, B2 and C2 dropped
    step(1, 64'hA2, 0, 0);
    step(1, 64'hB2, 0, 0);
    step(1, 64'hC2, 1, 1);
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_data", o_data, NOP);
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_ready", 64'(o_ready), 64'd1);
    step(0, 0, 1, 0);
    exp_rx.push_back(64'hA2);
    check_rx("flush_full");

    // flush with one held and a real in_fire: D consumed, E dropped
    step(1, 64'hD, 0, 0);
    step(1, 64'hE, 1, 1);
    chk("flush1_valid", 64'(o_valid), 64'd0);
    step(0, 0, 1, 0);
    exp_rx.push_back(64'hD);
    check_rx("flush_one");

    // reset mid-stream with two held
    step(1, 64'hF, 0, 0);
    step(1, 64'h1F, 0, 0);
    chk("prerst_count", 64'(o_count), 64'd2);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_data", o_data, NOP);
    chk("arst_count", 64'(o_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rel_ready0", 64'(o_ready), 64'd0);
    step(1, 64'h77, 1, 0);
    chk("rel_ready1", 64'(o_ready), 64'd1);
    chk("rel_valid", 64'(o_valid), 64'd0);
    step(0, 0, 1, 0);
    check_rx("rst_drop");

    // stall counter saturation on the 4-bit instance
    s_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    @(posedge clk);
    #1 s_valid = 1'b0;
    chk("sat_valid", 64'(s_o_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1 chk("sat_cnt5", 64'(s_stall), 64'd5);
    repeat (15) @(posedge clk);
    #1 chk("sat_cnt15", 64'(s_stall), 64'd15);
    repeat (5) @(posedge clk);
    #1 chk("sat_hold", 64'(s_stall), 64'd15);
    chk("sat_data", 64'(s_o_data), 64'h5A);

    // random traffic, scoreboard does the checking
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    rx.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
